// File: rtl/avst_uart_tx.sv
// Avalon-ST byte sink feeding an 8N1 UART transmitter through a small FIFO.
// Packets end with GAP_BITS idle bit-times; SOP/EOP misuse pulses proto_err.
module avst_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sink_data,
    input  logic       sink_valid,
    input  logic       sink_startofpacket,
    input  logic       sink_endofpacket,
    output logic       sink_ready,
    output logic       tx,
    output logic       busy,
    output logic       proto_err
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned GapW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [ADDR_W:0]  CntFull  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [7:0]        shift_q, shift_d;
    logic              eop_q, eop_d;
    logic              tx_q, tx_d;

    logic [8:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              in_pkt_q, in_pkt_d;
    logic              proto_err_q, proto_err_d;

    logic              push;
    logic              pop;
    logic [8:0]        head;

    assign sink_ready = (count_q < CntFull);
    assign push       = sink_valid && sink_ready;
    assign pop        = (state_q == StIdle) && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

    assign tx        = tx_q;
    assign busy      = (state_q != StIdle) || (count_q != '0);
    assign proto_err = proto_err_q;

    // Storage is not reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sink_endofpacket, sink_data};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The offending byte is still queued; tracking resyncs to its own flags.
    always_comb begin
        in_pkt_d    = in_pkt_q;
        proto_err_d = 1'b0;
        if (push) begin
            proto_err_d = sink_startofpacket ? in_pkt_q : !in_pkt_q;
            if (sink_endofpacket) begin
                in_pkt_d = 1'b0;
            end else if (sink_startofpacket) begin
                in_pkt_d = 1'b1;
            end
        end
    end

    // tx_d is the line level of the state being entered, so tx is registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        eop_d   = eop_q;
        tx_d    = tx_q;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = head[7:0];
                    eop_d   = head[8];
                    baud_d  = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_q == BaudLast) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    tx_d   = 1'b1;
                    if (eop_q && (GAP_BITS > 0)) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StGap: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (gap_q == GapLast) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            shift_q     <= '0;
            eop_q       <= 1'b0;
            tx_q        <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_pkt_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            shift_q     <= shift_d;
            eop_q       <= eop_d;
            tx_q        <= tx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_pkt_q    <= in_pkt_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_avst_uart_tx.sv
// Directed bench for avst_uart_tx: CLKS_PER_BIT=4, one instance with a 2-bit gap
// and one with no gap; a behavioural UART receiver decodes the line of dut_a.
module tb_avst_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_data;
    logic       a_valid, a_sop, a_eop;
    logic       a_ready, tx_a, busy_a, perr_a;
    logic [7:0] b_data;
    logic       b_valid, b_sop, b_eop;
    logic       b_ready, tx_b, busy_b, perr_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int perr_cnt_a = 0;
    int perr_cnt_b = 0;
    int idle_cyc;

    logic [7:0] rxq[$];
    int         rxt[$];
    logic       tx_prev = 1'b1;

    avst_uart_tx #(
        .CLKS_PER_BIT(4), .DEPTH(4), .ADDR_W(2), .GAP_BITS(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sink_data(a_data), .sink_valid(a_valid),
        .sink_startofpacket(a_sop), .sink_endofpacket(a_eop), .sink_ready(a_ready),
        .tx(tx_a), .busy(busy_a), .proto_err(perr_a)
    );

    avst_uart_tx #(
        .CLKS_PER_BIT(4), .DEPTH(4), .ADDR_W(2), .GAP_BITS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sink_data(b_data), .sink_valid(b_valid),
        .sink_startofpacket(b_sop), .sink_endofpacket(b_eop), .sink_ready(b_ready),
        .tx(tx_b), .busy(busy_b), .proto_err(perr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (perr_a) perr_cnt_a <= perr_cnt_a + 1;
        if (perr_b) perr_cnt_b <= perr_cnt_b + 1;
    end

    // Mid-bit sampling receiver; start cycle recorded as the edge count.
    always begin : rx_model
        logic [7:0] b;
        int         t0;
        @(negedge clk);
        if (tx_prev && !tx_a) begin
            t0 = cyc;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = tx_a;
            end
            repeat (4) @(negedge clk);
            rxq.push_back(b);
            rxt.push_back(t0);
        end
        tx_prev = tx_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame(input logic [7:0] b);
        logic [39:0] f;
        f = '1;
        for (int i = 0; i < 4; i++) f[i] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 4; i++) f[4 + 4 * j + i] = b[j];
        end
        return f;
    endfunction

    task automatic capture(input int n, input bit sel, output logic [127:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            cap[i] = sel ? tx_b : tx_a;
            step();
        end
    endtask

    task automatic wait_idle(input string tag, input bit sel, input int budget);
        int n;
        n = 0;
        while ((sel ? busy_b : busy_a) && n < budget) begin
            step();
            n++;
        end
        idle_cyc = cyc;
        chk(tag, {127'b0, (sel ? busy_b : busy_a)}, 128'd0);
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic s, input logic e);
        a_valid = v;
        a_data  = d;
        a_sop   = s;
        a_eop   = e;
    endtask

    initial begin
        logic [127:0] cap;
        logic [127:0] exp;
        int           idx;
        int           n_acc;
        int           first_full;
        int           guard;
        int           base;
        bit           acc;
        bit           stray;

        rst_n = 1'b0;
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        b_valid = 1'b0; b_data = 8'h00; b_sop = 1'b0; b_eop = 1'b0;
        #22;
        chk("rst_tx", tx_a, 1);
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_perr", perr_a, 0);
        step();
        rst_n = 1'b1;
        step();
        step();

        // Single byte 0xA5, SOP+EOP: frame then 8 gap cycles.
        drive_a(1'b1, 8'hA5, 1'b1, 1'b1);
        step();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_tx_before_pop", tx_a, 1);
        chk("t1_busy_queued", busy_a, 1);
        step();
        capture(48, 1'b0, cap);
        exp = '0;
        exp[39:0]  = frame(8'hA5);
        exp[47:40] = 8'hFF;
        chk("t1_waveform", cap, exp);
        chk("t1_busy_after_gap", busy_a, 0);
        chk("t1_no_perr", perr_cnt_a, 0);
        repeat (4) step();
        rxq.delete();
        rxt.delete();

        // Burst 0x01..0x06 with valid held; ready may stall the source.
        idx = 0; n_acc = 0; first_full = -1; guard = 0;
        drive_a(1'b1, 8'h01, 1'b1, 1'b0);
        while (idx < 6 && guard < 2000) begin
            acc = a_ready;
            step();
            if (acc) begin
                idx++;
                n_acc++;
                if (idx < 6) drive_a(1'b1, 8'(idx + 1), 1'b0, idx == 5);
                else drive_a(1'b0, 8'h00, 1'b0, 1'b0);
            end
            if (!a_ready && first_full < 0) first_full = n_acc;
            guard++;
        end
        chk("burst_all_accepted", idx, 6);
        chk("burst_full_after", first_full, 5);
        wait_idle("burst_idle", 1'b0, 600);
        chk("burst_rx_count", rxq.size(), 6);
        for (int i = 0; i < rxq.size(); i++) chk("burst_byte", rxq[i], i + 1);
        for (int i = 1; i < rxt.size(); i++) chk("burst_period", rxt[i] - rxt[i-1], 41);
        if (rxt.size() == 6) chk("burst_gap_after_last", idle_cyc - rxt[5], 48);
        chk("burst_no_perr", perr_cnt_a, 0);
        repeat (4) step();
        rxq.delete();
        rxt.delete();

        // Push coincident with pop while count is 3.
        drive_a(1'b1, 8'h01, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 8'h02, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 8'h03, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 8'h04, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (38) step();
        chk("pp_ready_at3", a_ready, 1);
        drive_a(1'b1, 8'h05, 1'b0, 1'b0);
        step();
        chk("pp_ready_after_pushpop", a_ready, 1);
        drive_a(1'b1, 8'h06, 1'b0, 1'b1);
        step();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pp_ready_full", a_ready, 0);
        wait_idle("pp_idle", 1'b0, 600);
        chk("pp_rx_count", rxq.size(), 6);
        for (int i = 0; i < rxq.size(); i++) chk("pp_byte", rxq[i], i + 1);
        repeat (4) step();
        rxq.delete();
        rxt.delete();

        // No-SOP byte outside a packet, then SOP twice in a row.
        base = perr_cnt_a;
        drive_a(1'b1, 8'h3C, 1'b0, 1'b0);
        step();
        chk("pe_pulse1", perr_a, 1);
        drive_a(1'b1, 8'h5A, 1'b1, 1'b0);
        step();
        chk("pe_legal_sop", perr_a, 0);
        drive_a(1'b1, 8'hC3, 1'b1, 1'b1);
        step();
        chk("pe_pulse2", perr_a, 1);
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("pe_pulse_end", perr_a, 0);
        wait_idle("pe_idle", 1'b0, 600);
        chk("pe_count", perr_cnt_a - base, 2);
        chk("pe_rx_count", rxq.size(), 3);
        if (rxq.size() == 3) begin
            chk("pe_byte0", rxq[0], 8'h3C);
            chk("pe_byte1", rxq[1], 8'h5A);
            chk("pe_byte2", rxq[2], 8'hC3);
        end
        repeat (4) step();

        // Reset during DATA bit 3 of 0x00 with two bytes queued.
        drive_a(1'b1, 8'h00, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 8'h11, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 8'h22, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (16) step();
        chk("rm_tx_low_bit3", tx_a, 0);
        rst_n = 1'b0;
        #1;
        chk("rm_tx", tx_a, 1);
        chk("rm_ready", a_ready, 1);
        chk("rm_busy", busy_a, 0);
        step();
        step();
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (100) begin
            step();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) stray = 1'b1;
        end
        chk("rm_no_residual", stray, 0);
        rxq.delete();
        rxt.delete();

        // GAP_BITS=0: 0xFF then 0x00, one idle cycle between frames.
        b_valid = 1'b1; b_data = 8'hFF; b_sop = 1'b1; b_eop = 1'b1;
        step();
        b_data = 8'h00;
        step();
        b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
        capture(82, 1'b1, cap);
        exp = '0;
        exp[39:0]  = frame(8'hFF);
        exp[40]    = 1'b1;
        exp[80:41] = frame(8'h00);
        exp[81]    = 1'b1;
        chk("g0_waveform", cap, exp);
        chk("g0_busy", busy_b, 0);
        chk("g0_no_perr", perr_cnt_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
